// File: rtl/uart_pkg.sv
// Shared types and baud-timing helper for the uart_txrx UART.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_bit_cycles(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tick is high during the last cycle of the loaded period.
module uart_bit_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign tick = (cnt == W'(1));

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART transmitter and receiver sharing one baud setting.
// Optional macro UART_FRAME_ERR_EN adds the sticky rx_frame_err output.
module uart_txrx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 90_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       rx_data_ready,
  input  logic       rx_clear,
`ifdef UART_FRAME_ERR_EN
  output logic       rx_frame_err,
`endif
  output logic [7:0] rx_data
);

  localparam int BIT_CYCLES = calc_bit_cycles(CLK_FREQ, BAUD);
  localparam int TW = $clog2(BIT_CYCLES + 1);
  localparam logic [TW-1:0] FULL_BIT = TW'(BIT_CYCLES);
  localparam logic [TW-1:0] HALF_BIT = TW'(BIT_CYCLES / 2);

  if (BIT_CYCLES < 4) begin : g_bit_cycles_check
    $error("uart_txrx: BIT_CYCLES must be at least 4");
  end

  // ---------------- transmitter ----------------
  uart_state_e          tx_state, tx_state_nxt;
  logic [DATA_BITS-1:0] tx_shift;
  logic [2:0]           tx_idx;
  logic                 tx_load, tx_tick;

  uart_bit_timer #(.W(TW)) u_tx_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tx_load),
    .load_val (FULL_BIT),
    .tick     (tx_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= IDLE;
    else     tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_load      = 1'b0;
    case (tx_state)
      IDLE: begin
        if (tx_start) begin
          tx_state_nxt = START;
          tx_load      = 1'b1;
        end else begin
          tx_state_nxt = IDLE;
        end
      end
      START: begin
        if (tx_tick) begin
          tx_state_nxt = DATA;
          tx_load      = 1'b1;
        end else begin
          tx_state_nxt = START;
        end
      end
      DATA: begin
        if (tx_tick) begin
          tx_load      = 1'b1;
          tx_state_nxt = (tx_idx == 3'd7) ? STOP : DATA;
        end else begin
          tx_state_nxt = DATA;
        end
      end
      STOP: begin
        if (tx_tick) tx_state_nxt = IDLE;
        else         tx_state_nxt = STOP;
      end
      default: tx_state_nxt = IDLE;
    endcase
  end

  // txd is registered so each bit change lands exactly on a timer boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= '0;
      tx_idx   <= 3'd0;
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (tx_state)
        IDLE: begin
          if (tx_start) begin
            tx_shift <= tx_data;
            tx_idx   <= 3'd0;
            txd      <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        START: begin
          if (tx_tick) begin
            txd      <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
          end
        end
        DATA: begin
          if (tx_tick) begin
            if (tx_idx == 3'd7) begin
              txd <= 1'b1;
            end else begin
              txd      <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
              tx_idx   <= tx_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (tx_tick) tx_busy <= 1'b0;
        end
        default: begin
          txd     <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  uart_state_e          rx_state, rx_state_nxt;
  logic [1:0]           rx_sync;
  logic                 rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic [2:0]           rx_idx;
  logic                 rx_wait;
  logic                 rx_load, rx_tick, rx_done, rx_bad;
  logic [TW-1:0]        rx_load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_sync <= 2'b11;
    else     rx_sync <= {rx_sync[0], rxd};
  end

  assign rx_bit = rx_sync[1];

  uart_bit_timer #(.W(TW)) u_rx_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (rx_load),
    .load_val (rx_load_val),
    .tick     (rx_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= IDLE;
    else     rx_state <= rx_state_nxt;
  end

  // A half-bit load in START puts every later sample at mid-bit.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_load      = 1'b0;
    rx_load_val  = FULL_BIT;
    rx_done      = 1'b0;
    rx_bad       = 1'b0;
    case (rx_state)
      IDLE: begin
        if (!rx_bit) begin
          rx_state_nxt = START;
          rx_load      = 1'b1;
          rx_load_val  = HALF_BIT;
        end else begin
          rx_state_nxt = IDLE;
        end
      end
      START: begin
        if (rx_tick) begin
          rx_state_nxt = rx_bit ? IDLE : DATA;
          rx_load      = ~rx_bit;
        end else begin
          rx_state_nxt = START;
        end
      end
      DATA: begin
        if (rx_tick) begin
          rx_load      = 1'b1;
          rx_state_nxt = (rx_idx == 3'd7) ? STOP : DATA;
        end else begin
          rx_state_nxt = DATA;
        end
      end
      STOP: begin
        if (rx_tick) begin
          rx_done      = rx_bit;
          rx_bad       = ~rx_bit;
          rx_state_nxt = rx_bit ? IDLE : STOP;
        end else if (rx_wait && rx_bit) begin
          rx_state_nxt = IDLE;
        end else begin
          rx_state_nxt = STOP;
        end
      end
      default: rx_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift <= '0;
      rx_idx   <= 3'd0;
      rx_wait  <= 1'b0;
    end else begin
      if (rx_state == START) begin
        rx_idx <= 3'd0;
      end else if (rx_state == DATA && rx_tick) begin
        rx_shift <= {rx_bit, rx_shift[DATA_BITS-1:1]};
        rx_idx   <= rx_idx + 3'd1;
      end
      if (rx_bad)                    rx_wait <= 1'b1;
      else if (rx_state_nxt == IDLE) rx_wait <= 1'b0;
    end
  end

  // A completing byte beats a simultaneous rx_clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data       <= 8'h00;
      rx_data_ready <= 1'b0;
    end else if (rx_done) begin
      rx_data       <= rx_shift;
      rx_data_ready <= 1'b1;
    end else if (rx_clear) begin
      rx_data_ready <= 1'b0;
    end
  end

`ifdef UART_FRAME_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           rx_frame_err <= 1'b0;
    else if (rx_done)  rx_frame_err <= 1'b0;
    else if (rx_bad)   rx_frame_err <= 1'b1;
    else if (rx_clear) rx_frame_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_txrx.sv
// Directed self-checking bench for uart_txrx at BIT_CYCLES = 10.
module tb_uart_txrx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int BT       = 100;   // one bit time in time units (10 clocks of 10)

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rxd_tb;
  logic       lb;
  logic       txd;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       rx_data_ready;
  logic       rx_clear;
  logic [7:0] rx_data;
`ifdef UART_FRAME_ERR_EN
  logic       rx_frame_err;
`endif

  int checks   = 0;
  int failures = 0;

  assign rxd = lb ? txd : rxd_tb;

  always #5 clk = ~clk;

  uart_txrx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .txd           (txd),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_busy       (tx_busy),
    .rx_data_ready (rx_data_ready),
    .rx_clear      (rx_clear),
`ifdef UART_FRAME_ERR_EN
    .rx_frame_err  (rx_frame_err),
`endif
    .rx_data       (rx_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
  endtask

  task automatic pulse_clear();
    rx_clear = 1'b1;
    step();
    rx_clear = 1'b0;
  endtask

  task automatic wait_ready(input int limit, output bit ok);
    int n = 0;
    while (rx_data_ready !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    ok = (rx_data_ready === 1'b1);
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int n = 0;
    while (tx_busy !== 1'b0 && n < limit) begin
      step();
      n++;
    end
    ok = (tx_busy === 1'b0);
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic stop, input int bt);
    rxd_tb = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rxd_tb = d[i];
      #(bt);
    end
    rxd_tb = stop;
    #(bt);
    rxd_tb = 1'b1;
    #(bt);
  endtask

  task automatic test_reset();
    step();
    checks++;
    if ({txd, tx_busy, rx_data_ready, rx_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_init got txd=%b busy=%b rdy=%b data=%h exp 1 0 0 00",
               txd, tx_busy, rx_data_ready, rx_data);
    end
  endtask

  task automatic test_tx_a5();
    logic [9:0] frame;
    frame = 10'b1101001010;   // stop, A5 msb..lsb, start
    lb = 1'b0;
    pulse_start(8'hA5);
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (txd !== frame[i / 10]) begin
        failures++;
        $display("FAIL tx_a5_txd cycle=%0d got=%b exp=%b", i, txd, frame[i / 10]);
      end
      checks++;
      if (tx_busy !== 1'b1) begin
        failures++;
        $display("FAIL tx_a5_busy cycle=%0d got=%b exp=1", i, tx_busy);
      end
      step();
    end
    checks++;
    if (tx_busy !== 1'b0 || txd !== 1'b1) begin
      failures++;
      $display("FAIL tx_a5_end got busy=%b txd=%b exp busy=0 txd=1", tx_busy, txd);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] pat [3];
    bit ok;
    pat = '{8'h00, 8'hFF, 8'h55};
    lb = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      pulse_start(pat[k]);
      wait_ready(200, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL loop_ready_timeout byte=%0d got rdy=%b exp 1", k, rx_data_ready);
      end
      checks++;
      if (rx_data !== pat[k]) begin
        failures++;
        $display("FAIL loop_data byte=%0d got=%h exp=%h", k, rx_data, pat[k]);
      end
      pulse_clear();
      checks++;
      if (rx_data_ready !== 1'b0) begin
        failures++;
        $display("FAIL loop_clear byte=%0d got rdy=%b exp 0", k, rx_data_ready);
      end
      wait_idle(200, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL loop_idle_timeout byte=%0d got busy=%b exp 0", k, tx_busy);
      end
    end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    bit saw;
    lb = 1'b1;
    pulse_start(8'h3A);
    step_n(4);
    pulse_start(8'h99);
    step_n(40);
    pulse_start(8'hC3);
    step_n(53);
    checks++;
    if (tx_busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_last_cycle got=%b exp=1", tx_busy);
    end
    tx_data  = 8'h5E;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    checks++;
    if (tx_busy !== 1'b0 || txd !== 1'b1) begin
      failures++;
      $display("FAIL busy_fall got busy=%b txd=%b exp busy=0 txd=1", tx_busy, txd);
    end
    step();
    checks++;
    if (tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL start_at_fall_ignored got busy=%b exp 0", tx_busy);
    end
    wait_ready(50, ok);
    checks++;
    if (!ok || rx_data !== 8'h3A) begin
      failures++;
      $display("FAIL ignore_first_byte got rdy=%b data=%h exp rdy=1 data=3a", rx_data_ready, rx_data);
    end
    pulse_clear();
    step_n(150);
    checks++;
    if (rx_data_ready !== 1'b0 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_no_extra got rdy=%b busy=%b exp 0 0", rx_data_ready, tx_busy);
    end
    pulse_start(8'h17);
    wait_ready(200, ok);
    checks++;
    if (!ok || rx_data !== 8'h17) begin
      failures++;
      $display("FAIL pre_overrun got rdy=%b data=%h exp rdy=1 data=17", rx_data_ready, rx_data);
    end
    wait_idle(50, ok);
    pulse_start(8'h6B);
    step_n(80);
    rx_clear = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 35; i++) begin
      step();
      if (rx_data_ready === 1'b1 && rx_data === 8'h6B) saw = 1'b1;
    end
    rx_clear = 1'b0;
    checks++;
    if (saw !== 1'b1) begin
      failures++;
      $display("FAIL clear_vs_done got saw_ready_new=%b exp 1", saw);
    end
    checks++;
    if (rx_data !== 8'h6B) begin
      failures++;
      $display("FAIL clear_vs_done_data got=%h exp=6b", rx_data);
    end
  endtask

  task automatic test_glitch_badstop();
    lb     = 1'b0;
    rxd_tb = 1'b1;
    step_n(5);
    rxd_tb = 1'b0;
    step_n(3);
    rxd_tb = 1'b1;
    step_n(100);
    checks++;
    if (rx_data_ready !== 1'b0 || rx_data !== 8'h6B) begin
      failures++;
      $display("FAIL glitch got rdy=%b data=%h exp rdy=0 data=6b", rx_data_ready, rx_data);
    end
    drive_rx(8'hE7, 1'b0, BT);
    step_n(5);
    checks++;
    if (rx_data_ready !== 1'b0 || rx_data !== 8'h6B) begin
      failures++;
      $display("FAIL bad_stop got rdy=%b data=%h exp rdy=0 data=6b", rx_data_ready, rx_data);
    end
`ifdef UART_FRAME_ERR_EN
    checks++;
    if (rx_frame_err !== 1'b1) begin
      failures++;
      $display("FAIL frame_err_set got=%b exp=1", rx_frame_err);
    end
    pulse_clear();
    checks++;
    if (rx_frame_err !== 1'b0) begin
      failures++;
      $display("FAIL frame_err_clear got=%b exp=0", rx_frame_err);
    end
`endif
  endtask

  task automatic test_baud_error();
    int bts [2];
    bts = '{103, 97};
    lb  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_rx(8'h00, 1'b0, BT);
      step();
      drive_rx(8'h3C, 1'b1, bts[k]);
      step();
      checks++;
      if (rx_data_ready !== 1'b1 || rx_data !== 8'h3C) begin
        failures++;
        $display("FAIL baud_err bt=%0d got rdy=%b data=%h exp rdy=1 data=3c",
                 bts[k], rx_data_ready, rx_data);
      end
`ifdef UART_FRAME_ERR_EN
      checks++;
      if (rx_frame_err !== 1'b0) begin
        failures++;
        $display("FAIL frame_err_good_clears bt=%0d got=%b exp=0", bts[k], rx_frame_err);
      end
`endif
      if (k == 0) pulse_clear();
    end
  endtask

  task automatic test_reset_midframe();
    lb = 1'b1;
    pulse_start(8'h81);
    step_n(35);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({txd, tx_busy, rx_data_ready, rx_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_midframe got txd=%b busy=%b rdy=%b data=%h exp 1 0 0 00",
               txd, tx_busy, rx_data_ready, rx_data);
    end
`ifdef UART_FRAME_ERR_EN
    checks++;
    if (rx_frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_frame_err got=%b exp=0", rx_frame_err);
    end
`endif
    step_n(2);
    rst = 1'b0;
    step_n(150);
    checks++;
    if (txd !== 1'b1 || tx_busy !== 1'b0 || rx_data_ready !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_idle got txd=%b busy=%b rdy=%b exp 1 0 0",
               txd, tx_busy, rx_data_ready);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    rxd_tb   = 1'b1;
    lb       = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    rx_clear = 1'b0;
    test_reset();
    step_n(2);
    rst = 1'b0;
    step_n(3);
    test_tx_a5();
    step_n(5);
    test_loopback();
    step_n(5);
    test_busy_ignore();
    step_n(5);
    test_glitch_badstop();
    step_n(5);
    test_baud_error();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
